// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-bank controller.
//   - Register address map of the PWM configuration bank.
//   - Controller FSM state encoding.
//   - Default highest legal register address.
package spi_ctrl_pkg;

   localparam int ADDR_W           = 7;
   localparam int DATA_W           = 8;
   localparam int MAX_ADDR_DEFAULT = 4;

   localparam int ADDR_EN_OUT_7_0    = 0;
   localparam int ADDR_EN_OUT_15_8   = 1;
   localparam int ADDR_PWM_MODE_7_0  = 2;
   localparam int ADDR_PWM_MODE_15_8 = 3;
   localparam int ADDR_PWM_DUTY      = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      CHECK = 1'b1
   } state_t;

endpackage

// File: rtl/reg_commit_timer.sv
// Commit-timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : count up this cycle
//   clear      : return to zero (has priority over run)
//   expired    : counter is all-ones
module reg_commit_timer #(
   parameter int TIMEOUT_W = 12
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic expired
);

   logic [TIMEOUT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = &cnt;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI-to-PWM register-bank controller.
// Accepts decoded SPI writes, validates them, stages accepted data in shadow
// registers and commits all staged registers atomically to the active PWM
// configuration at a PWM period boundary (or on timeout / immediately when
// SYNC_COMMIT = 0).
//
// Handshake: a transfer happens on a rising clk edge with txn_valid && txn_ready;
// txn_rw/txn_addr/txn_data are captured only on that edge, and the requester
// holds them stable until then. txn_ready is a flop, low during reset and
// during the one-cycle CHECK state.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   txn_valid/txn_ready            transaction handshake
//   txn_rw, txn_addr, txn_data     transaction payload (rw: 1 = write)
//   pwm_period_end                 end-of-period pulse from the PWM
//   en_reg_out_7_0 .. pwm_duty_cycle  active registers 0..4
//   cfg_pending                    staged writes awaiting commit
//   commit_pulse                   one-cycle pulse after each commit
//   err_pulse                      high during the CHECK cycle of a rejected txn
//   err_count                      saturating rejected-transaction count
//   dbg_state                      current FSM state
module spi_reg_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int MAX_ADDR    = MAX_ADDR_DEFAULT,
   parameter int SYNC_COMMIT = 1,
   parameter int TIMEOUT_W   = 12,
   parameter int ERR_W       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              txn_valid,
   output logic              txn_ready,
   input  logic              txn_rw,
   input  logic [ADDR_W-1:0] txn_addr,
   input  logic [DATA_W-1:0] txn_data,
   input  logic              pwm_period_end,
   output logic [DATA_W-1:0] en_reg_out_7_0,
   output logic [DATA_W-1:0] en_reg_out_15_8,
   output logic [DATA_W-1:0] en_reg_pwm_mode_7_0,
   output logic [DATA_W-1:0] en_reg_pwm_mode_15_8,
   output logic [DATA_W-1:0] pwm_duty_cycle,
   output logic              cfg_pending,
   output logic              commit_pulse,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_count,
   output state_t            dbg_state
);

   localparam int                NREG       = MAX_ADDR + 1;
   localparam logic [ADDR_W-1:0] MAX_ADDR_L = ADDR_W'(MAX_ADDR);

   state_t              state, state_next;
   logic                lat_rw;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_data;
   logic [DATA_W-1:0]   shadow [NREG];
   logic [DATA_W-1:0]   active [NREG];
   logic [NREG-1:0]     dirty, dirty_next, set_mask;
   logic                transfer, reject, accept, commit, expired;

   assign transfer = txn_valid && txn_ready;
   assign reject   = (state == CHECK) && (!lat_rw || (lat_addr > MAX_ADDR_L));
   assign accept   = (state == CHECK) && !reject;
   assign commit   = (|dirty) && (pwm_period_end || (SYNC_COMMIT == 0) || expired);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (transfer) state_next = CHECK;
         CHECK:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      set_mask = '0;
      for (int i = 0; i < NREG; i++) begin
         set_mask[i] = accept && (lat_addr == ADDR_W'(i));
      end
   end

   // A write landing in the commit cycle keeps its dirty bit: the commit
   // consumes the old shadow value and the new one waits for the next commit.
   assign dirty_next = (commit ? '0 : dirty) | set_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         txn_ready    <= 1'b0;
         lat_rw       <= 1'b0;
         lat_addr     <= '0;
         lat_data     <= '0;
         dirty        <= '0;
         cfg_pending  <= 1'b0;
         commit_pulse <= 1'b0;
         err_count    <= '0;
         for (int i = 0; i < NREG; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         state        <= state_next;
         txn_ready    <= (state_next == IDLE);
         dirty        <= dirty_next;
         cfg_pending  <= |dirty_next;
         commit_pulse <= commit;
         if (transfer) begin
            lat_rw   <= txn_rw;
            lat_addr <= txn_addr;
            lat_data <= txn_data;
         end
         if (reject && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
         end
         for (int i = 0; i < NREG; i++) begin
            if (set_mask[i]) shadow[i] <= lat_data;
            if (commit && dirty[i]) active[i] <= shadow[i];
         end
      end
   end

   reg_commit_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     ((|dirty) && !commit),
      .clear   (commit || !(|dirty)),
      .expired (expired)
   );

   assign err_pulse            = reject;
   assign dbg_state            = state;
   assign en_reg_out_7_0       = active[ADDR_EN_OUT_7_0];
   assign en_reg_out_15_8      = active[ADDR_EN_OUT_15_8];
   assign en_reg_pwm_mode_7_0  = active[ADDR_PWM_MODE_7_0];
   assign en_reg_pwm_mode_15_8 = active[ADDR_PWM_MODE_15_8];
   assign pwm_duty_cycle       = active[ADDR_PWM_DUTY];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: main instance with SYNC_COMMIT = 1 and TIMEOUT_W = 4,
// plus a second instance with SYNC_COMMIT = 0 sharing the same inputs.
module tb_spi_reg_ctrl;
   import spi_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       txn_valid = 1'b0;
   logic       txn_rw = 1'b0;
   logic [6:0] txn_addr = '0;
   logic [7:0] txn_data = '0;
   logic       pwm_period_end = 1'b0;

   logic       txn_ready, cfg_pending, commit_pulse, err_pulse;
   logic [7:0] out_lo, out_hi, mode_lo, mode_hi, duty;
   logic [3:0] err_count;
   state_t     dbg_state;

   logic       a_ready, a_pending, a_commit, a_err;
   logic [7:0] a_out_lo, a_out_hi, a_mode_lo, a_mode_hi, a_duty;
   logic [3:0] a_err_count;
   state_t     a_state;

   int checks = 0;
   int failures = 0;
   int commit_seen = 0;
   int err_seen = 0;

   always #5 clk = ~clk;

   spi_reg_ctrl #(.SYNC_COMMIT(1), .TIMEOUT_W(4), .ERR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .txn_valid(txn_valid), .txn_ready(txn_ready),
      .txn_rw(txn_rw), .txn_addr(txn_addr), .txn_data(txn_data),
      .pwm_period_end(pwm_period_end),
      .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
      .en_reg_pwm_mode_7_0(mode_lo), .en_reg_pwm_mode_15_8(mode_hi),
      .pwm_duty_cycle(duty), .cfg_pending(cfg_pending),
      .commit_pulse(commit_pulse), .err_pulse(err_pulse),
      .err_count(err_count), .dbg_state(dbg_state)
   );

   spi_reg_ctrl #(.SYNC_COMMIT(0), .TIMEOUT_W(4), .ERR_W(4)) dut_async (
      .clk(clk), .rst_n(rst_n), .txn_valid(txn_valid), .txn_ready(a_ready),
      .txn_rw(txn_rw), .txn_addr(txn_addr), .txn_data(txn_data),
      .pwm_period_end(pwm_period_end),
      .en_reg_out_7_0(a_out_lo), .en_reg_out_15_8(a_out_hi),
      .en_reg_pwm_mode_7_0(a_mode_lo), .en_reg_pwm_mode_15_8(a_mode_hi),
      .pwm_duty_cycle(a_duty), .cfg_pending(a_pending),
      .commit_pulse(a_commit), .err_pulse(a_err),
      .err_count(a_err_count), .dbg_state(a_state)
   );

   always @(posedge clk) begin
      if (commit_pulse === 1'b1) commit_seen++;
      if (err_pulse === 1'b1) err_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for txn_ready, then presents one transaction for one edge.
   // Returns #1 after the transfer edge, i.e. inside the CHECK cycle.
   task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] data);
      int waited = 0;
      while (txn_ready !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      checks++;
      if (txn_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_ready: txn_ready=%b required 1 (addr %0d)", txn_ready, addr);
      end
      txn_valid = 1'b1;
      txn_rw    = rw;
      txn_addr  = addr;
      txn_data  = data;
      tick();
      txn_valid = 1'b0;
   endtask

   task automatic pulse_period_end();
      pwm_period_end = 1'b1;
      tick();
      pwm_period_end = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (txn_ready !== 1'b0 || cfg_pending !== 1'b0 || commit_pulse !== 1'b0 ||
          err_pulse !== 1'b0 || err_count !== 4'd0) begin
         failures++;
         $display("FAIL reset_ctrl: ready=%b pend=%b cp=%b ep=%b ec=%0d required all 0",
                  txn_ready, cfg_pending, commit_pulse, err_pulse, err_count);
      end
      checks++;
      if ({out_lo, out_hi, mode_lo, mode_hi, duty} !== 40'h0) begin
         failures++;
         $display("FAIL reset_regs: %h %h %h %h %h required 0",
                  out_lo, out_hi, mode_lo, mode_hi, duty);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (txn_ready !== 1'b1 || dbg_state !== IDLE) begin
         failures++;
         $display("FAIL reset_release: ready=%b state=%0d required 1/IDLE", txn_ready, dbg_state);
      end
   endtask

   task automatic test_sync_commit();
      int c0;
      send(1'b1, 7'd4, 8'h80);
      checks++;
      if (dbg_state !== CHECK || txn_ready !== 1'b0) begin
         failures++;
         $display("FAIL check_state: state=%0d ready=%b required CHECK/0", dbg_state, txn_ready);
      end
      repeat (10) tick();
      checks++;
      if (duty !== 8'h00 || cfg_pending !== 1'b1) begin
         failures++;
         $display("FAIL sync_hold: duty=%h pend=%b required 00/1", duty, cfg_pending);
      end
      c0 = commit_seen;
      pulse_period_end();
      checks++;
      if (duty !== 8'h80 || cfg_pending !== 1'b0 || commit_pulse !== 1'b1) begin
         failures++;
         $display("FAIL sync_commit: duty=%h pend=%b cp=%b required 80/0/1",
                  duty, cfg_pending, commit_pulse);
      end
      tick();
      checks++;
      if (commit_seen - c0 !== 1) begin
         failures++;
         $display("FAIL sync_commit_count: %0d required 1", commit_seen - c0);
      end
   endtask

   task automatic test_coalesce();
      int c0;
      send(1'b1, 7'd0, 8'h0F);
      send(1'b1, 7'd0, 8'hF0);
      send(1'b1, 7'd2, 8'h55);
      tick();
      c0 = commit_seen;
      pulse_period_end();
      tick();
      checks++;
      if (out_lo !== 8'hF0 || mode_lo !== 8'h55) begin
         failures++;
         $display("FAIL coalesce_vals: out_lo=%h mode_lo=%h required F0/55", out_lo, mode_lo);
      end
      checks++;
      if (out_hi !== 8'h00 || mode_hi !== 8'h00 || duty !== 8'h80) begin
         failures++;
         $display("FAIL coalesce_untouched: out_hi=%h mode_hi=%h duty=%h required 00/00/80",
                  out_hi, mode_hi, duty);
      end
      checks++;
      if (commit_seen - c0 !== 1) begin
         failures++;
         $display("FAIL coalesce_commits: %0d required 1", commit_seen - c0);
      end
   endtask

   task automatic test_reject();
      int e0;
      e0 = err_seen;
      send(1'b1, 7'd5, 8'hAA);
      send(1'b0, 7'd1, 8'h77);
      tick();
      tick();
      checks++;
      if (err_seen - e0 !== 2 || err_count !== 4'd2) begin
         failures++;
         $display("FAIL reject_count: pulses=%0d err_count=%0d required 2/2", err_seen - e0, err_count);
      end
      checks++;
      if (cfg_pending !== 1'b0 || out_hi !== 8'h00 || a_out_hi !== 8'h00) begin
         failures++;
         $display("FAIL reject_noeffect: pend=%b out_hi=%h a_out_hi=%h required 0/00/00",
                  cfg_pending, out_hi, a_out_hi);
      end
      for (int i = 0; i < 20; i++) begin
         send(1'($urandom_range(0, 1)), 7'(8 + i), 8'(i));
      end
      tick();
      tick();
      checks++;
      if (err_count !== 4'd15 || a_err_count !== 4'd15) begin
         failures++;
         $display("FAIL reject_saturate: err_count=%0d a=%0d required 15", err_count, a_err_count);
      end
   endtask

   task automatic test_collision();
      send(1'b1, 7'd1, 8'h11);
      tick();
      send(1'b1, 7'd1, 8'h22);
      pulse_period_end();   // commit edge coincides with the end of CHECK
      checks++;
      if (out_hi !== 8'h11 || cfg_pending !== 1'b1) begin
         failures++;
         $display("FAIL collision_first: out_hi=%h pend=%b required 11/1", out_hi, cfg_pending);
      end
      tick();
      pulse_period_end();
      checks++;
      if (out_hi !== 8'h22 || cfg_pending !== 1'b0) begin
         failures++;
         $display("FAIL collision_second: out_hi=%h pend=%b required 22/0", out_hi, cfg_pending);
      end
   endtask

   task automatic test_async_latency();
      // Transfer at edge N; shadow at N+1; active at N+2 in the SYNC_COMMIT=0 instance.
      send(1'b1, 7'd4, 8'h5A);
      tick();
      checks++;
      if (a_duty !== 8'h80 || a_pending !== 1'b1) begin
         failures++;
         $display("FAIL async_n1: a_duty=%h a_pend=%b required 80/1", a_duty, a_pending);
      end
      tick();
      checks++;
      if (a_duty !== 8'h5A || a_pending !== 1'b0 || a_commit !== 1'b1 || duty !== 8'h80) begin
         failures++;
         $display("FAIL async_n2: a_duty=%h a_pend=%b a_cp=%b duty=%h required 5A/0/1/80",
                  a_duty, a_pending, a_commit, duty);
      end
      pulse_period_end();
      checks++;
      if (duty !== 8'h5A) begin
         failures++;
         $display("FAIL async_flush: duty=%h required 5A", duty);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      send(1'b1, 7'd3, 8'h3C);
      tick();
      checks++;
      if (cfg_pending !== 1'b1 || mode_hi !== 8'h00) begin
         failures++;
         $display("FAIL timeout_start: pend=%b mode_hi=%h required 1/00", cfg_pending, mode_hi);
      end
      // Dirty sets at edge D; counter is 0 in the first pending cycle and 15
      // in the 16th, so the forced commit lands on edge D+16.
      while (mode_hi !== 8'h3C && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 16 || commit_pulse !== 1'b1 || cfg_pending !== 1'b0) begin
         failures++;
         $display("FAIL timeout_commit: edges=%0d cp=%b pend=%b mode_hi=%h required 16/1/0/3C",
                  n, commit_pulse, cfg_pending, mode_hi);
      end
   endtask

   task automatic test_reset_mid();
      int c0;
      send(1'b1, 7'd2, 8'h99);
      tick();
      txn_valid = 1'b1;
      txn_rw    = 1'b1;
      txn_addr  = 7'd0;
      txn_data  = 8'h12;
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_lo, out_hi, mode_lo, mode_hi, duty} !== 40'h0 || cfg_pending !== 1'b0 ||
          txn_ready !== 1'b0 || err_count !== 4'd0 || commit_pulse !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: regs=%h pend=%b ready=%b ec=%0d cp=%b required all 0",
                  {out_lo, out_hi, mode_lo, mode_hi, duty}, cfg_pending, txn_ready,
                  err_count, commit_pulse);
      end
      tick();
      txn_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (txn_ready !== 1'b1 || cfg_pending !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_release: ready=%b pend=%b required 1/0", txn_ready, cfg_pending);
      end
      c0 = commit_seen;
      pulse_period_end();
      tick();
      checks++;
      if (mode_lo !== 8'h00 || out_lo !== 8'h00 || commit_seen - c0 !== 0) begin
         failures++;
         $display("FAIL reset_mid_lost: mode_lo=%h out_lo=%h commits=%0d required 00/00/0",
                  mode_lo, out_lo, commit_seen - c0);
      end
   endtask

   initial begin
      test_reset();
      test_sync_commit();
      test_coalesce();
      test_reject();
      test_collision();
      test_async_latency();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
